// File: rtl/bus_unit.sv
// Bus interface stage: drives the multiplexed address/data pins from the PC or data pointer,
// owns the PC, captures read bytes into IR/operand buffer and synchronises READY/HOLD.
module bus_unit #(
    parameter int unsigned SYNC_STG = 2,
    parameter logic [15:0] PC_RST   = 16'h0000
) (
    input  logic        clk_,
    input  logic        rst_,
    input  logic [11:0] oenb,
    input  logic        pc_ld,
    input  logic [15:0] pc_in,
    input  logic [15:0] dptr,
    input  logic [7:0]  wdata,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic [7:0]  a_hi,
    output logic        a_hi_oe,
    input  logic        ready_pin,
    input  logic        hold_pin,
    output logic [1:0]  ipin,
    output logic        holda,
    output logic [15:0] pc,
    output logic [7:0]  ir,
    output logic        ir_new,
    output logic [15:0] opnd,
    output logic [1:0]  opnd_cnt,
    output logic [7:0]  rdata,
    output logic        rd_strobe
);

    localparam int unsigned OeAddl = 0;
    localparam int unsigned OeAddh = 1;
    localparam int unsigned OeData = 2;
    localparam int unsigned OeRegr = 3;
    localparam int unsigned OeRegw = 4;
    localparam int unsigned OeCwr  = 5;
    localparam int unsigned OeMore = 6;
    localparam int unsigned OeUppc = 7;
    localparam int unsigned OePdat = 8;
    localparam int unsigned OeNext = 9;
    localparam int unsigned OeAle  = 10;
    localparam int unsigned OeRd3  = 11;

    logic [15:0] addr_sel;
    logic [15:0] pc_q, pc_d, addr_q, addr_d, opnd_q, opnd_d;
    logic [7:0]  ir_q, ir_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]  opnd_cnt_q, opnd_cnt_d;
    logic        ir_new_q, ir_new_d, rd_strobe_q, rd_strobe_d, holda_q, holda_d;
    logic        ready_s, hold_s;

    // REGR, MORE and NEXT carry no meaning for this stage.
    logic unused_oenb;
    assign unused_oenb = oenb[OeRegr] ^ oenb[OeMore] ^ oenb[OeNext];

    if (SYNC_STG == 0) begin : g_no_sync
        assign ready_s = ready_pin;
        assign hold_s  = hold_pin;
    end else begin : g_sync
        logic [SYNC_STG-1:0] rdy_sync_q, rdy_sync_d, hld_sync_q, hld_sync_d;

        always_comb begin
            rdy_sync_d    = rdy_sync_q;
            hld_sync_d    = hld_sync_q;
            rdy_sync_d[0] = ready_pin;
            hld_sync_d[0] = hold_pin;
            for (int i = 1; i < SYNC_STG; i++) begin
                rdy_sync_d[i] = rdy_sync_q[i-1];
                hld_sync_d[i] = hld_sync_q[i-1];
            end
        end

        always_ff @(posedge clk_ or posedge rst_) begin
            if (rst_) begin
                rdy_sync_q <= '0;
                hld_sync_q <= '0;
            end else begin
                rdy_sync_q <= rdy_sync_d;
                hld_sync_q <= hld_sync_d;
            end
        end

        assign ready_s = rdy_sync_q[SYNC_STG-1];
        assign hold_s  = hld_sync_q[SYNC_STG-1];
    end

    always_comb begin
        addr_sel = oenb[OePdat] ? dptr : pc_q;
        ad_oe    = oenb[OeAddl] | oenb[OeData];
        a_hi_oe  = oenb[OeAddh];
        if (oenb[OeAle]) begin
            ad_out = addr_sel[7:0];
            a_hi   = addr_sel[15:8];
        end else begin
            ad_out = oenb[OeAddl] ? addr_q[7:0] : wdata_q;
            a_hi   = addr_q[15:8];
        end
    end

    always_comb begin
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        opnd_d      = opnd_q;
        opnd_cnt_d  = opnd_cnt_q;
        rdata_d     = rdata_q;
        ir_new_d    = 1'b0;
        rd_strobe_d = 1'b0;
        holda_d     = hold_s & ~oenb[OeAddh];

        if (oenb[OeAle]) begin
            addr_d  = addr_sel;
            wdata_d = wdata;
        end

        if (pc_ld) begin
            pc_d = pc_in;
        end else if (oenb[OeUppc]) begin
            pc_d = pc_q + 16'd1;
        end

        // Opcode capture wins over operand capture if both are strobed.
        if (oenb[OeRd3]) begin
            if (oenb[OeCwr]) begin
                ir_d        = ad_in;
                opnd_d      = '0;
                opnd_cnt_d  = '0;
                ir_new_d    = 1'b1;
                rdata_d     = ad_in;
                rd_strobe_d = 1'b1;
            end else if (oenb[OeRegw]) begin
                if (opnd_cnt_q == 2'd0) begin
                    opnd_d[7:0] = ad_in;
                    opnd_cnt_d  = 2'd1;
                end else begin
                    opnd_d[15:8] = ad_in;
                    opnd_cnt_d   = 2'd2;
                end
                rdata_d     = ad_in;
                rd_strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            pc_q        <= PC_RST;
            addr_q      <= '0;
            wdata_q     <= '0;
            ir_q        <= '0;
            opnd_q      <= '0;
            opnd_cnt_q  <= '0;
            rdata_q     <= '0;
            ir_new_q    <= 1'b0;
            rd_strobe_q <= 1'b0;
            holda_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ir_q        <= ir_d;
            opnd_q      <= opnd_d;
            opnd_cnt_q  <= opnd_cnt_d;
            rdata_q     <= rdata_d;
            ir_new_q    <= ir_new_d;
            rd_strobe_q <= rd_strobe_d;
            holda_q     <= holda_d;
        end
    end

    assign ipin      = {hold_s, ready_s};
    assign holda     = holda_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign ir_new    = ir_new_q;
    assign opnd      = opnd_q;
    assign opnd_cnt  = opnd_cnt_q;
    assign rdata     = rdata_q;
    assign rd_strobe = rd_strobe_q;

endmodule

// File: tb/tb_bus_unit.sv
// Bench for bus_unit: directed bus-cycle table, randomized run against a reference model,
// and hand sequences for PC wrap, synchroniser latency, HOLD and asynchronous reset.
module tb_bus_unit;

    localparam int unsigned SYNC = 2;
    localparam logic [15:0] PCR  = 16'h0000;

    localparam logic [11:0] T1F = 12'h403;  // ALE_|ADDH|ADDL
    localparam logic [11:0] T2F = 12'h082;  // ADDH|UPPC
    localparam logic [11:0] T3F = 12'h822;  // ADDH|C_WR|3RD_
    localparam logic [11:0] T3O = 12'h812;  // ADDH|REGW|3RD_
    localparam logic [11:0] W1  = 12'h503;  // ALE_|PDAT|ADDH|ADDL
    localparam logic [11:0] W2  = 12'h106;  // PDAT|ADDH|DATA
    localparam logic [11:0] W3  = 12'h906;  // 3RD_|PDAT|ADDH|DATA

    logic        clk_, rst_;
    logic [11:0] oenb;
    logic        pc_ld, ready_pin, hold_pin;
    logic [15:0] pc_in, dptr;
    logic [7:0]  wdata, ad_in;
    logic [7:0]  ad_out, a_hi, ir, rdata;
    logic        ad_oe, a_hi_oe, holda, ir_new, rd_strobe;
    logic [1:0]  ipin, opnd_cnt;
    logic [15:0] pc, opnd;

    bus_unit #(.SYNC_STG(SYNC), .PC_RST(PCR)) dut (
        .clk_(clk_), .rst_(rst_), .oenb(oenb), .pc_ld(pc_ld), .pc_in(pc_in), .dptr(dptr),
        .wdata(wdata), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .a_hi(a_hi),
        .a_hi_oe(a_hi_oe), .ready_pin(ready_pin), .hold_pin(hold_pin), .ipin(ipin),
        .holda(holda), .pc(pc), .ir(ir), .ir_new(ir_new), .opnd(opnd),
        .opnd_cnt(opnd_cnt), .rdata(rdata), .rd_strobe(rd_strobe)
    );

    initial clk_ = 1'b0;
    always #5 clk_ = ~clk_;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: bus-level view of the stage.
    int          m_pc;
    logic [7:0]  m_ir, m_rdata, m_wdata;
    logic [15:0] m_addr;
    logic        m_irn, m_rds, m_holda;
    logic [7:0]  opq[$];
    bit          rdy_h[$];
    bit          hld_h[$];

    function automatic bit ready_s();
        if (SYNC == 0) return ready_pin;
        return (rdy_h.size() >= SYNC) ? rdy_h[rdy_h.size() - SYNC] : 1'b0;
    endfunction

    function automatic bit hold_s();
        if (SYNC == 0) return hold_pin;
        return (hld_h.size() >= SYNC) ? hld_h[hld_h.size() - SYNC] : 1'b0;
    endfunction

    function automatic logic [15:0] m_opnd();
        logic [7:0] lo, hi;
        lo = (opq.size() >= 1) ? opq[0] : 8'h00;
        hi = (opq.size() >= 2) ? opq[opq.size() - 1] : 8'h00;
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_pc = int'(PCR); m_ir = 0; m_rdata = 0; m_wdata = 0; m_addr = 0;
        m_irn = 0; m_rds = 0; m_holda = 0;
        opq.delete(); rdy_h.delete(); hld_h.delete();
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        @(posedge clk_); #1;
        rst_ = 1'b0;
        model_reset();
    endtask

    // One clock: check combinational outputs at negedge, advance the model, check after edge.
    task automatic step();
        logic [15:0] sel;
        bit rs, hs;
        @(negedge clk_);
        sel = oenb[8] ? dptr : 16'(m_pc);
        rs = ready_s();
        hs = hold_s();
        chk("ad_oe", ad_oe, oenb[0] | oenb[2]);
        chk("a_hi_oe", a_hi_oe, oenb[1]);
        chk("ipin_pre", ipin, {hs, rs});
        if (oenb[10]) begin
            chk("ad_out_t1", ad_out, sel[7:0]);
            chk("a_hi_t1", a_hi, sel[15:8]);
        end else begin
            chk("a_hi_late", a_hi, m_addr[15:8]);
            if (!oenb[0]) chk("ad_out_wdata", ad_out, m_wdata);
        end
        if (oenb[10]) begin
            m_addr = sel;
            m_wdata = wdata;
        end
        if (pc_ld) m_pc = int'(pc_in);
        else if (oenb[7]) m_pc = (m_pc + 1) % 65536;
        m_irn = 0;
        m_rds = 0;
        if (oenb[11] && (oenb[5] || oenb[4])) begin
            m_rdata = ad_in;
            m_rds = 1;
            if (oenb[5]) begin
                m_ir = ad_in;
                m_irn = 1;
                opq.delete();
            end else begin
                opq.push_back(ad_in);
            end
        end
        m_holda = hs & ~oenb[1];
        rdy_h.push_back(ready_pin);
        hld_h.push_back(hold_pin);
        @(posedge clk_); #1;
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("ir_new", ir_new, m_irn);
        chk("rd_strobe", rd_strobe, m_rds);
        chk("rdata", rdata, m_rdata);
        chk("opnd", opnd, m_opnd());
        chk("opnd_cnt", opnd_cnt, (opq.size() > 2) ? 2 : opq.size());
        chk("holda", holda, m_holda);
        chk("ipin_post", ipin, {hold_s(), ready_s()});
    endtask

    typedef struct {
        logic [11:0] oe;
        logic [15:0] dp;
        logic [7:0]  wd;
        logic [7:0]  din;
        logic [7:0]  e_ad;
        logic [7:0]  e_ahi;
        logic        e_oe;
        logic [15:0] e_pc;
        logic [7:0]  e_ir;
        logic        e_irn;
        logic        e_rds;
        logic [1:0]  e_cnt;
        logic [15:0] e_opnd;
    } vec_t;

    vec_t tbl[16];
    bit   ipin_seen[6];
    bit   ipin_exp[6];

    initial begin
        tbl[0]  = '{T1F, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 1, 16'h0000, 8'h00, 0, 0, 0, 16'h0000};
        tbl[1]  = '{T2F, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0001, 8'h00, 0, 0, 0, 16'h0000};
        tbl[2]  = '{T3F, 16'h0000, 8'h00, 8'h3E, 8'h00, 8'h00, 0, 16'h0001, 8'h3E, 1, 1, 0, 16'h0000};
        tbl[3]  = '{12'h000, 16'h0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0001, 8'h3E, 0, 0, 0, 16'h0000};
        tbl[4]  = '{T1F, 16'h0000, 8'h00, 8'h00, 8'h01, 8'h00, 1, 16'h0001, 8'h3E, 0, 0, 0, 16'h0000};
        tbl[5]  = '{T2F, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0002, 8'h3E, 0, 0, 0, 16'h0000};
        tbl[6]  = '{T3F, 16'h0000, 8'h00, 8'h21, 8'h00, 8'h00, 0, 16'h0002, 8'h21, 1, 1, 0, 16'h0000};
        tbl[7]  = '{T1F, 16'h0000, 8'h00, 8'h00, 8'h02, 8'h00, 1, 16'h0002, 8'h21, 0, 0, 0, 16'h0000};
        tbl[8]  = '{T2F, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0003, 8'h21, 0, 0, 0, 16'h0000};
        tbl[9]  = '{T3O, 16'h0000, 8'h00, 8'h34, 8'h00, 8'h00, 0, 16'h0003, 8'h21, 0, 1, 1, 16'h0034};
        tbl[10] = '{T1F, 16'h0000, 8'h00, 8'h00, 8'h03, 8'h00, 1, 16'h0003, 8'h21, 0, 0, 1, 16'h0034};
        tbl[11] = '{T2F, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 16'h0004, 8'h21, 0, 0, 1, 16'h0034};
        tbl[12] = '{T3O, 16'h0000, 8'h00, 8'h12, 8'h00, 8'h00, 0, 16'h0004, 8'h21, 0, 1, 2, 16'h1234};
        tbl[13] = '{W1,  16'hA055, 8'h77, 8'h00, 8'h55, 8'hA0, 1, 16'h0004, 8'h21, 0, 0, 2, 16'h1234};
        tbl[14] = '{W2,  16'hA055, 8'h00, 8'h00, 8'h77, 8'hA0, 1, 16'h0004, 8'h21, 0, 0, 2, 16'h1234};
        tbl[15] = '{W3,  16'hA055, 8'h00, 8'hFF, 8'h77, 8'hA0, 1, 16'h0004, 8'h21, 0, 0, 2, 16'h1234};

        rst_ = 1'b0; oenb = '0; pc_ld = 0; pc_in = '0; dptr = '0; wdata = '0; ad_in = '0;
        ready_pin = 1'b1; hold_pin = 1'b0;
        #2;
        do_reset();
        chk("rst_pc", pc, PCR);
        chk("rst_ir", ir, 8'h00);
        chk("rst_opnd", opnd, 16'h0);
        chk("rst_cnt", opnd_cnt, 2'd0);
        chk("rst_pulses", {ir_new, rd_strobe, holda}, 3'b000);

        // Directed bus cycles: opcode fetch, three-byte fetch, memory write.
        for (int i = 0; i < 16; i++) begin
            oenb = tbl[i].oe; dptr = tbl[i].dp; wdata = tbl[i].wd; ad_in = tbl[i].din;
            #1;
            chk($sformatf("v%0d_ad_out", i), ad_out, tbl[i].e_ad);
            chk($sformatf("v%0d_a_hi", i), a_hi, tbl[i].e_ahi);
            chk($sformatf("v%0d_ad_oe", i), ad_oe, tbl[i].e_oe);
            step();
            chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("v%0d_ir", i), ir, tbl[i].e_ir);
            chk($sformatf("v%0d_ir_new", i), ir_new, tbl[i].e_irn);
            chk($sformatf("v%0d_rd_strobe", i), rd_strobe, tbl[i].e_rds);
            chk($sformatf("v%0d_cnt", i), opnd_cnt, tbl[i].e_cnt);
            chk($sformatf("v%0d_opnd", i), opnd, tbl[i].e_opnd);
        end

        // PC load to FFFF, wrap on UPPC, and pc_ld beating UPPC.
        oenb = '0; pc_ld = 1; pc_in = 16'hFFFF;
        step();
        chk("pc_load", pc, 16'hFFFF);
        pc_ld = 0; oenb = T2F;
        step();
        chk("pc_wrap", pc, 16'h0000);
        pc_ld = 1; pc_in = 16'h1234;
        step();
        chk("pc_ld_prio", pc, 16'h1234);
        pc_ld = 0; oenb = '0;

        // READY low for three cycles appears on ipin[0] two cycles later.
        ready_pin = 1; step(); step();
        for (int i = 0; i < 6; i++) begin
            ready_pin = (i >= 1 && i <= 3) ? 1'b0 : 1'b1;
            ipin_exp[i] = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
            step();
            ipin_seen[i] = ipin[0];
        end
        for (int i = 0; i < 6; i++) chk($sformatf("ready_sync%0d", i), ipin_seen[i], ipin_exp[i]);

        // HOLD: no acknowledge while ADDH is driven, then release and drop.
        hold_pin = 1; oenb = 12'h002;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("holda_busy%0d", i), holda, 1'b0);
        end
        oenb = '0;
        step();
        chk("holda_set", holda, 1'b1);
        hold_pin = 0;
        step(); chk("holda_keep0", holda, 1'b1);
        step(); chk("holda_keep1", holda, 1'b1);
        step(); chk("holda_drop", holda, 1'b0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            oenb = 12'($urandom);
            pc_ld = ($urandom_range(0, 7) == 0);
            pc_in = 16'($urandom);
            dptr = 16'($urandom);
            wdata = 8'($urandom);
            ad_in = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ready_pin = ~ready_pin;
            if ($urandom_range(0, 5) == 0) hold_pin = ~hold_pin;
            step();
        end

        // Asynchronous reset right after a capture edge clears strobes immediately.
        do_reset();
        pc_ld = 0;
        oenb = T1F; step();
        oenb = T2F; step();
        oenb = T3F; ad_in = 8'h5A; step();
        chk("pre_rst_ir_new", ir_new, 1'b1);
        #2 rst_ = 1'b1;
        #1;
        chk("arst_ir", ir, 8'h00);
        chk("arst_strobes", {ir_new, rd_strobe}, 2'b00);
        @(posedge clk_); #1; rst_ = 1'b0; model_reset();

        // Asynchronous reset mid-T2 after the PC incremented.
        oenb = T1F; step();
        oenb = T2F; step();
        chk("pre_rst_pc", pc, 16'h0001);
        oenb = 12'h002;
        #2 rst_ = 1'b1;
        #1;
        chk("arst_pc", pc, PCR);
        chk("arst_ir2", ir, 8'h00);
        @(posedge clk_); #1; rst_ = 1'b0; model_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
